// File: rtl/wr_tx_frame_arbiter.sv
// Shares the 16-bit TX symbol path between a PTP and a bulk data source.
// Frames packets with SOF/EOF delimiters, inserts an idle gap and aborts underrun frames with ERR.
module wr_tx_frame_arbiter #(
    parameter int IFG_WORDS = 6,
    parameter bit PTP_PRIO  = 1'b1
) (
    input  logic        clk_125m,
    input  logic        rst_n,
    input  logic        tx_enable,
    input  logic [15:0] ptp_data,
    input  logic        ptp_eof,
    input  logic        ptp_valid,
    output logic        ptp_ready,
    input  logic [15:0] dat_data,
    input  logic        dat_eof,
    input  logic        dat_valid,
    output logic        dat_ready,
    output logic [15:0] tx_data,
    output logic        tx_k,
    output logic [1:0]  grant,
    output logic        underrun,
    output logic [15:0] frame_cnt,
    output logic [2:0]  state_dbg
);

    // Handshake: a source word is transferred on a rising edge where valid and ready are both 1.
    // ready is registered and only depends on arbiter state, never on valid.

    localparam logic [15:0] SYM_IDLE = 16'hBC50;
    localparam logic [15:0] SYM_SOF  = 16'hFB55;
    localparam logic [15:0] SYM_EOF  = 16'hFD50;
    localparam logic [15:0] SYM_ERR  = 16'hFE50;

    localparam logic [2:0] ST_GAP  = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_SOF  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_EOF  = 3'd4;

    localparam int            CW       = $clog2(IFG_WORDS + 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(IFG_WORDS);
    localparam logic [CW-1:0] GAP_LAST = CW'(1);

    logic [2:0]    state;
    logic [CW-1:0] gap_cnt;
    logic          rr_ptr;     // 0: PTP wins a tie, 1: data wins a tie
    logic          win_ptp;
    logic          sel_valid;
    logic          sel_eof;
    logic [15:0]   sel_data;

    assign state_dbg = state;

    always_comb begin
        win_ptp = ptp_valid;
        if (!PTP_PRIO && ptp_valid && dat_valid) begin
            win_ptp = (rr_ptr == 1'b0);
        end
    end

    always_comb begin
        sel_valid = dat_valid;
        sel_eof   = dat_eof;
        sel_data  = dat_data;
        if (grant[0]) begin
            sel_valid = ptp_valid;
            sel_eof   = ptp_eof;
            sel_data  = ptp_data;
        end
    end

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_GAP;
            gap_cnt   <= GAP_LOAD;
            tx_data   <= SYM_IDLE;
            tx_k      <= 1'b1;
            ptp_ready <= 1'b0;
            dat_ready <= 1'b0;
            grant     <= 2'b00;
            underrun  <= 1'b0;
            frame_cnt <= 16'd0;
            rr_ptr    <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                ST_GAP: begin
                    tx_data <= SYM_IDLE;
                    tx_k    <= 1'b1;
                    if (gap_cnt <= GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_LAST;
                    end
                end
                ST_IDLE: begin
                    tx_data <= SYM_IDLE;
                    tx_k    <= 1'b1;
                    if (tx_enable && (ptp_valid || dat_valid)) begin
                        // Ready rises together with SOF so the first word follows SOF with no bubble.
                        state     <= ST_SOF;
                        tx_data   <= SYM_SOF;
                        grant     <= {~win_ptp, win_ptp};
                        ptp_ready <= win_ptp;
                        dat_ready <= ~win_ptp;
                        rr_ptr    <= win_ptp;
                    end
                end
                ST_SOF, ST_DATA: begin
                    if (sel_valid) begin
                        tx_data <= sel_data;
                        tx_k    <= 1'b0;
                        state   <= ST_DATA;
                        if (sel_eof) begin
                            state     <= ST_EOF;
                            ptp_ready <= 1'b0;
                            dat_ready <= 1'b0;
                        end
                    end else begin
                        tx_data   <= SYM_ERR;
                        tx_k      <= 1'b1;
                        underrun  <= 1'b1;
                        ptp_ready <= 1'b0;
                        dat_ready <= 1'b0;
                        grant     <= 2'b00;
                        state     <= ST_GAP;
                        gap_cnt   <= GAP_LOAD;
                    end
                end
                ST_EOF: begin
                    tx_data   <= SYM_EOF;
                    tx_k      <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    grant     <= 2'b00;
                    state     <= ST_GAP;
                    gap_cnt   <= GAP_LOAD;
                end
                default: begin
                    tx_data   <= SYM_IDLE;
                    tx_k      <= 1'b1;
                    ptp_ready <= 1'b0;
                    dat_ready <= 1'b0;
                    grant     <= 2'b00;
                    state     <= ST_GAP;
                    gap_cnt   <= GAP_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wr_tx_frame_arbiter.sv
// Directed bench for wr_tx_frame_arbiter: one strict-priority instance and one round-robin instance
// share the source inputs; sel picks which instance's outputs are observed and handshaken.
module tb_wr_tx_frame_arbiter;

    localparam logic [16:0] K_IDLE = 17'h1BC50;
    localparam logic [16:0] K_SOF  = 17'h1FB55;
    localparam logic [16:0] K_EOF  = 17'h1FD50;
    localparam logic [16:0] K_ERR  = 17'h1FE50;

    logic        clk_125m = 1'b0;
    logic        rst_n;
    logic        tx_enable;
    logic [15:0] ptp_data;
    logic        ptp_eof;
    logic        ptp_valid;
    logic [15:0] dat_data;
    logic        dat_eof;
    logic        dat_valid;
    logic        sel;

    logic        p_ptp_ready, p_dat_ready, p_tx_k, p_underrun;
    logic [15:0] p_tx_data, p_frame_cnt;
    logic [1:0]  p_grant;
    logic [2:0]  p_state;
    logic        r_ptp_ready, r_dat_ready, r_tx_k, r_underrun;
    logic [15:0] r_tx_data, r_frame_cnt;
    logic [1:0]  r_grant;
    logic [2:0]  r_state;

    logic        o_ptp_ready, o_dat_ready, o_tx_k, o_underrun;
    logic [15:0] o_tx_data, o_frame_cnt;
    logic [1:0]  o_grant;

    int errors = 0;
    int checks = 0;

    logic [16:0] ptp_src[$];
    logic [16:0] dat_src[$];
    logic [16:0] exp_q[$];
    logic [16:0] tr_sym[$];
    logic [1:0]  tr_grant[$];
    logic        tr_und[$];
    logic        tr_dready[$];

    always #4 clk_125m = ~clk_125m;

    wr_tx_frame_arbiter #(.IFG_WORDS(6), .PTP_PRIO(1'b1)) u_prio (
        .clk_125m(clk_125m), .rst_n(rst_n), .tx_enable(tx_enable),
        .ptp_data(ptp_data), .ptp_eof(ptp_eof), .ptp_valid(ptp_valid), .ptp_ready(p_ptp_ready),
        .dat_data(dat_data), .dat_eof(dat_eof), .dat_valid(dat_valid), .dat_ready(p_dat_ready),
        .tx_data(p_tx_data), .tx_k(p_tx_k), .grant(p_grant), .underrun(p_underrun),
        .frame_cnt(p_frame_cnt), .state_dbg(p_state)
    );

    wr_tx_frame_arbiter #(.IFG_WORDS(6), .PTP_PRIO(1'b0)) u_rr (
        .clk_125m(clk_125m), .rst_n(rst_n), .tx_enable(tx_enable),
        .ptp_data(ptp_data), .ptp_eof(ptp_eof), .ptp_valid(ptp_valid), .ptp_ready(r_ptp_ready),
        .dat_data(dat_data), .dat_eof(dat_eof), .dat_valid(dat_valid), .dat_ready(r_dat_ready),
        .tx_data(r_tx_data), .tx_k(r_tx_k), .grant(r_grant), .underrun(r_underrun),
        .frame_cnt(r_frame_cnt), .state_dbg(r_state)
    );

    assign o_ptp_ready = sel ? r_ptp_ready : p_ptp_ready;
    assign o_dat_ready = sel ? r_dat_ready : p_dat_ready;
    assign o_tx_data   = sel ? r_tx_data   : p_tx_data;
    assign o_tx_k      = sel ? r_tx_k      : p_tx_k;
    assign o_grant     = sel ? r_grant     : p_grant;
    assign o_underrun  = sel ? r_underrun  : p_underrun;
    assign o_frame_cnt = sel ? r_frame_cnt : p_frame_cnt;

    // ---------------- driver tasks ----------------
    task automatic clear_trace();
        tr_sym.delete();
        tr_grant.delete();
        tr_und.delete();
        tr_dready.delete();
        exp_q.delete();
    endtask

    task automatic drive_idle();
        ptp_valid = 1'b0; ptp_eof = 1'b0; ptp_data = 16'h0;
        dat_valid = 1'b0; dat_eof = 1'b0; dat_data = 16'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ptp_src.delete();
        dat_src.delete();
        drive_idle();
        tx_enable = 1'b1;
        repeat (2) @(negedge clk_125m);
        rst_n = 1'b1;
        clear_trace();
    endtask

    // One clock: log the observed outputs at the falling edge, then present the next source words.
    // ready is registered, so valid & ready here is the transfer taken on the coming rising edge.
    task automatic cycle();
        @(negedge clk_125m);
        tr_sym.push_back({o_tx_k, o_tx_data});
        tr_grant.push_back(o_grant);
        tr_und.push_back(o_underrun);
        tr_dready.push_back(o_dat_ready);
        drive_idle();
        if (ptp_src.size() > 0) begin
            ptp_valid = 1'b1;
            {ptp_eof, ptp_data} = ptp_src[0];
        end
        if (dat_src.size() > 0) begin
            dat_valid = 1'b1;
            {dat_eof, dat_data} = dat_src[0];
        end
        if (ptp_valid && o_ptp_ready) void'(ptp_src.pop_front());
        if (dat_valid && o_dat_ready) void'(dat_src.pop_front());
    endtask

    function automatic logic [16:0] sym_at(int i);
        if (i < 0 || i >= tr_sym.size()) return 17'hx;
        return tr_sym[i];
    endfunction

    function automatic int first_active(int from);
        for (int i = from; i < tr_sym.size(); i++) begin
            if (tr_sym[i] !== K_IDLE) return i;
        end
        return -1;
    endfunction

    function automatic int first_sym(int from, logic [16:0] sym);
        for (int i = from; i < tr_sym.size(); i++) begin
            if (tr_sym[i] === sym) return i;
        end
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        sel = 1'b0;
        rst_n = 1'b1;
        tx_enable = 1'b1;
        drive_idle();
        #13;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_tx_data !== 16'hBC50 || o_tx_k !== 1'b1) begin
            errors++;
            $display("FAIL reset_symbol got %h k=%b want bc50 k=1", o_tx_data, o_tx_k);
        end
        checks++;
        if (o_grant !== 2'b00 || o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant got grant=%b underrun=%b want 00/0", o_grant, o_underrun);
        end
        checks++;
        if (o_frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt got %0d want 0", o_frame_cnt);
        end
        checks++;
        if (o_ptp_ready !== 1'b0 || o_dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b%b want 00", o_ptp_ready, o_dat_ready);
        end
        checks++;
        if (r_tx_data !== 16'hBC50 || r_tx_k !== 1'b1 || r_frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_rr got %h k=%b cnt=%0d want bc50 k=1 cnt=0", r_tx_data, r_tx_k, r_frame_cnt);
        end
        @(negedge clk_125m);
        rst_n = 1'b1;
    endtask

    task automatic test_ptp_frame();
        int s;
        sel = 1'b0;
        do_reset();
        ptp_src.push_back({1'b0, 16'h1111});
        ptp_src.push_back({1'b0, 16'h2222});
        ptp_src.push_back({1'b1, 16'h3333});
        exp_q.push_back(K_SOF);
        exp_q.push_back({1'b0, 16'h1111});
        exp_q.push_back({1'b0, 16'h2222});
        exp_q.push_back({1'b0, 16'h3333});
        exp_q.push_back(K_EOF);
        repeat (6) exp_q.push_back(K_IDLE);
        repeat (30) cycle();
        s = first_active(0);
        checks++;
        if (s < 0) begin
            errors++;
            $display("FAIL ptp_frame_start got none want fb55 within 30 cycles");
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (sym_at(s + i) !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ptp_frame_sym[%0d] got %h want %h", i, sym_at(s + i), exp_q[i]);
                end
            end
            checks++;
            if (tr_grant[s + 1] !== 2'b01) begin
                errors++;
                $display("FAIL ptp_frame_grant got %b want 01", tr_grant[s + 1]);
            end
        end
        checks++;
        if (o_frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ptp_frame_cnt got %0d want 1", o_frame_cnt);
        end
    endtask

    task automatic test_priority();
        int s;
        logic seen_dready;
        sel = 1'b0;
        do_reset();
        ptp_src.push_back({1'b0, 16'hA001});
        ptp_src.push_back({1'b1, 16'hA002});
        dat_src.push_back({1'b0, 16'hB001});
        dat_src.push_back({1'b0, 16'hB002});
        dat_src.push_back({1'b1, 16'hB003});
        exp_q.push_back(K_SOF);
        exp_q.push_back({1'b0, 16'hA001});
        exp_q.push_back({1'b0, 16'hA002});
        exp_q.push_back(K_EOF);
        repeat (6) exp_q.push_back(K_IDLE);
        exp_q.push_back(K_SOF);
        exp_q.push_back({1'b0, 16'hB001});
        exp_q.push_back({1'b0, 16'hB002});
        exp_q.push_back({1'b0, 16'hB003});
        exp_q.push_back(K_EOF);
        repeat (35) cycle();
        s = first_active(0);
        checks++;
        if (s < 0) begin
            errors++;
            $display("FAIL priority_start got none want fb55 within 35 cycles");
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (sym_at(s + i) !== exp_q[i]) begin
                    errors++;
                    $display("FAIL priority_sym[%0d] got %h want %h", i, sym_at(s + i), exp_q[i]);
                end
            end
            seen_dready = 1'b0;
            for (int i = 0; i < 10; i++) seen_dready |= (tr_dready[s + i] === 1'b1);
            checks++;
            if (seen_dready !== 1'b0) begin
                errors++;
                $display("FAIL priority_dat_ready got 1 during ptp frame want 0");
            end
            checks++;
            if (tr_grant[s] !== 2'b01 || tr_grant[s + 10] !== 2'b10) begin
                errors++;
                $display("FAIL priority_grant got %b,%b want 01,10", tr_grant[s], tr_grant[s + 10]);
            end
        end
        checks++;
        if (o_frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL priority_frame_cnt got %0d want 2", o_frame_cnt);
        end
    endtask

    task automatic test_round_robin();
        int idx;
        logic [1:0]  exp_grant[4];
        logic [16:0] exp_word[4];
        sel = 1'b1;
        do_reset();
        ptp_src.push_back({1'b1, 16'hC001});
        ptp_src.push_back({1'b1, 16'hC002});
        dat_src.push_back({1'b1, 16'hD001});
        dat_src.push_back({1'b1, 16'hD002});
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_word  = '{17'h0C001, 17'h0D001, 17'h0C002, 17'h0D002};
        repeat (60) cycle();
        idx = first_sym(0, K_SOF);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (idx < 0) begin
                errors++;
                $display("FAIL rr_frame%0d got no sof want sof", k);
            end else begin
                if (tr_grant[idx] !== exp_grant[k] || sym_at(idx + 1) !== exp_word[k]
                    || sym_at(idx + 2) !== K_EOF) begin
                    errors++;
                    $display("FAIL rr_frame%0d got grant=%b word=%h end=%h want grant=%b word=%h end=%h",
                             k, tr_grant[idx], sym_at(idx + 1), sym_at(idx + 2), exp_grant[k], exp_word[k], K_EOF);
                end
                idx = first_sym(idx + 1, K_SOF);
            end
        end
        checks++;
        if (o_frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL rr_frame_cnt got %0d want 4", o_frame_cnt);
        end
    endtask

    task automatic test_underrun();
        int s;
        int n_und;
        sel = 1'b0;
        do_reset();
        dat_src.push_back({1'b0, 16'h5A01});
        dat_src.push_back({1'b0, 16'h5A02});
        exp_q.push_back(K_SOF);
        exp_q.push_back({1'b0, 16'h5A01});
        exp_q.push_back({1'b0, 16'h5A02});
        exp_q.push_back(K_ERR);
        repeat (6) exp_q.push_back(K_IDLE);
        repeat (25) cycle();
        s = first_active(0);
        checks++;
        if (s < 0) begin
            errors++;
            $display("FAIL underrun_start got none want fb55 within 25 cycles");
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (sym_at(s + i) !== exp_q[i]) begin
                    errors++;
                    $display("FAIL underrun_sym[%0d] got %h want %h", i, sym_at(s + i), exp_q[i]);
                end
            end
            checks++;
            if (tr_und[s + 3] !== 1'b1 || tr_grant[s + 1] !== 2'b10) begin
                errors++;
                $display("FAIL underrun_pulse got und=%b grant=%b want 1/10", tr_und[s + 3], tr_grant[s + 1]);
            end
        end
        n_und = 0;
        foreach (tr_und[i]) if (tr_und[i] === 1'b1) n_und++;
        checks++;
        if (n_und != 1) begin
            errors++;
            $display("FAIL underrun_width got %0d cycles want 1", n_und);
        end
        checks++;
        if (o_frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL underrun_frame_cnt got %0d want 0", o_frame_cnt);
        end
    endtask

    task automatic test_tx_enable();
        int s;
        int bad;
        sel = 1'b0;
        do_reset();
        ptp_src.push_back({1'b0, 16'h7001});
        ptp_src.push_back({1'b0, 16'h7002});
        ptp_src.push_back({1'b1, 16'h7003});
        dat_src.push_back({1'b0, 16'h8001});
        dat_src.push_back({1'b1, 16'h8002});
        s = -1;
        for (int i = 0; i < 20 && s < 0; i++) begin
            cycle();
            if (tr_sym[tr_sym.size() - 1] === K_SOF) begin
                s = tr_sym.size() - 1;
                tx_enable = 1'b0;
            end
        end
        repeat (30) cycle();
        exp_q.push_back(K_SOF);
        exp_q.push_back({1'b0, 16'h7001});
        exp_q.push_back({1'b0, 16'h7002});
        exp_q.push_back({1'b0, 16'h7003});
        exp_q.push_back(K_EOF);
        checks++;
        if (s < 0) begin
            errors++;
            $display("FAIL txen_start got none want fb55 within 20 cycles");
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (sym_at(s + i) !== exp_q[i]) begin
                    errors++;
                    $display("FAIL txen_sym[%0d] got %h want %h", i, sym_at(s + i), exp_q[i]);
                end
            end
            bad = 0;
            for (int i = s + 5; i < tr_sym.size(); i++) begin
                if (tr_sym[i] !== K_IDLE || tr_dready[i] !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL txen_idle got %0d non-idle cycles want 0", bad);
            end
        end
        checks++;
        if (o_frame_cnt !== 16'd1 || dat_src.size() != 2) begin
            errors++;
            $display("FAIL txen_frame_cnt got cnt=%0d pending=%0d want 1/2", o_frame_cnt, dat_src.size());
        end
        tx_enable = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int n_sof;
        int s;
        sel = 1'b0;
        do_reset();
        ptp_src.push_back({1'b1, 16'h0A0A});
        for (int i = 0; i < 4; i++) ptp_src.push_back({1'b0, 16'h0B00 + 16'(i)});
        ptp_src.push_back({1'b1, 16'h0BFF});
        n_sof = 0;
        for (int i = 0; i < 40 && n_sof < 2; i++) begin
            cycle();
            if (tr_sym[tr_sym.size() - 1] === K_SOF) n_sof++;
        end
        repeat (2) cycle();
        checks++;
        if (n_sof != 2 || o_frame_cnt !== 16'd1 || o_grant !== 2'b01) begin
            errors++;
            $display("FAIL midrst_pre got sofs=%0d cnt=%0d grant=%b want 2/1/01", n_sof, o_frame_cnt, o_grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_tx_data !== 16'hBC50 || o_tx_k !== 1'b1 || o_grant !== 2'b00
            || o_ptp_ready !== 1'b0 || o_frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_state got %h k=%b grant=%b rdy=%b cnt=%0d want bc50/1/00/0/0",
                     o_tx_data, o_tx_k, o_grant, o_ptp_ready, o_frame_cnt);
        end
        ptp_src.delete();
        drive_idle();
        @(negedge clk_125m);
        rst_n = 1'b1;
        clear_trace();
        repeat (12) cycle();
        s = first_active(0);
        checks++;
        if (s >= 0) begin
            errors++;
            $display("FAIL midrst_after got %h at cycle %0d want only bc50", sym_at(s), s);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0;
        rst_n = 1'b1;
        tx_enable = 1'b1;
        drive_idle();
        test_reset();
        test_ptp_frame();
        test_priority();
        test_round_robin();
        test_underrun();
        test_tx_enable();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
